// File: rtl/sdram_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// sdram_traffic_gen_if
// User-port bundle between a traffic source (master) and the SDRAM controller
// (slave).
//   enable     master->slave  request strobe
//   write      master->slave  1 = write, 0 = read
//   addr       master->slave  word address
//   write_data master->slave  write payload
//   read_data  slave->master  read payload, valid when ready rises after a read
//   ready      slave->master  controller idle; falls = accepted, rises = complete
// ---------------------------------------------------------------------------
interface sdram_traffic_gen_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              ready;

    modport master (
        output enable, write, addr, write_data,
        input  read_data, ready
    );

    modport slave (
        input  enable, write, addr, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sdram_traffic_gen.sv
// ---------------------------------------------------------------------------
// sdram_traffic_gen
// Bring-up traffic generator and self-checker for the SDRAM controller user
// port. On start it writes a deterministic pattern over a window of NUM_WORDS
// addresses, reads the window back and compares every word.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a test (honoured only when idle or done)
//   busy            test in progress
//   done            test finished (level, held until next start)
//   pass            valid with done: no mismatches and no timeout
//   timeout         valid with done: a transaction exceeded TIMEOUT_CYC
//   err_count       saturating mismatch count
//   first_err_addr  address of the first mismatch
//   first_err_data  read data of the first mismatch
//   bus             controller user port (master side)
//
// Build option: define TGEN_LFSR_EN to replace the address-XOR pattern with a
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1) seeded with SEED at each phase start.
// ---------------------------------------------------------------------------
module sdram_traffic_gen #(
    parameter int              ADDR_W      = 24,
    parameter int              DATA_W      = 32,
    parameter int unsigned     START_ADDR  = 0,
    parameter int unsigned     NUM_WORDS   = 1024,
    parameter int unsigned     ADDR_STEP   = 1,
    parameter logic [31:0]     PAT_XOR     = 32'hA5A5_A5A5,
    parameter logic [31:0]     SEED        = 32'h0000_0001,
    parameter int unsigned     TIMEOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    sdram_traffic_gen_if.master bus
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  index;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] cur_pat;
    logic              rd_mismatch;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef TGEN_LFSR_EN
    logic [31:0] lfsr;

    // Right-shifting Galois form; tap mask holds x^32, x^22, x^2, x^1 terms.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [DATA_W-1:0] lfsr_data(input logic [31:0] s);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W; i++) d[i] = s[i % 32];
        return d;
    endfunction

    assign cur_pat = lfsr_data(lfsr);

    // PAT_XOR only shapes the address-XOR build.
    logic unused_pat_xor;
    assign unused_pat_xor = ^PAT_XOR;
`else
    localparam int PW_A = (ADDR_W > 32) ? ADDR_W : 32;
    localparam int PW   = (DATA_W > PW_A) ? DATA_W : PW_A;

    function automatic logic [DATA_W-1:0] addr_pattern(input logic [ADDR_W-1:0] a);
        logic [PW-1:0] wide;
        wide = PW'(a) ^ PW'(PAT_XOR);
        return wide[DATA_W-1:0];
    endfunction

    assign cur_pat = addr_pattern(bus.addr);

    // SEED only shapes the LFSR build.
    logic unused_seed;
    assign unused_seed = ^SEED;
`endif

    assign rd_mismatch = (state == RD_WAIT) && bus.ready && (bus.read_data != cur_pat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            index          <= '0;
            timer          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            bus.enable     <= 1'b0;
            bus.write      <= 1'b0;
            bus.addr       <= '0;
            bus.write_data <= '0;
`ifdef TGEN_LFSR_EN
            lfsr           <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_data <= '0;
                        bus.write      <= 1'b1;
                        bus.addr       <= ADDR_BASE;
                        index          <= '0;
`ifdef TGEN_LFSR_EN
                        lfsr           <= SEED;
`endif
                        state          <= WR_REQ;
                    end
                end

                WR_REQ, RD_REQ: begin
                    if (!bus.enable) begin
                        // A low ready here is controller init or a previous
                        // transaction, never an acceptance: wait for idle.
                        if (bus.ready) begin
                            bus.enable <= 1'b1;
                            timer      <= '0;
                            if (state == WR_REQ) bus.write_data <= cur_pat;
                        end
                    end else if (!bus.ready) begin
                        bus.enable <= 1'b0;
                        timer      <= timer + 1'b1;
                        state      <= (state == WR_REQ) ? WR_WAIT : RD_WAIT;
                    end else if (timer == TMR_LAST) begin
                        bus.enable <= 1'b0;
                        timeout    <= 1'b1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= 1'b0;
                        state      <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WR_WAIT, RD_WAIT: begin
                    if (bus.ready) begin
                        if (rd_mismatch) begin
                            err_count <= sat_inc(err_count);
                            if (err_count == 16'd0) begin
                                first_err_addr <= bus.addr;
                                first_err_data <= bus.read_data;
                            end
                        end
                        if (index == LAST_IDX) begin
                            if (state == WR_WAIT) begin
                                bus.write <= 1'b0;
                                bus.addr  <= ADDR_BASE;
                                index     <= '0;
`ifdef TGEN_LFSR_EN
                                lfsr      <= SEED;
`endif
                                state     <= RD_REQ;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= (err_count == 16'd0) && !rd_mismatch;
                                state <= DONE;
                            end
                        end else begin
                            bus.addr <= bus.addr + ADDR_INC;
                            index    <= index + 1'b1;
`ifdef TGEN_LFSR_EN
                            lfsr     <= lfsr_step(lfsr);
`endif
                            state    <= (state == WR_WAIT) ? WR_REQ : RD_REQ;
                        end
                    end else if (timer == TMR_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
